// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster counters, latency-aligned sync/blank and pixel gating
module vga_timing_gen #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int CLK_DIV     = 1,
  parameter int PIX_LATENCY = 1,
  parameter bit SYNC_POL    = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pixel_bw,
  output logic [9:0] horizCounter,
  output logic [9:0] vertCounter,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       pixel_out,
  output logic       frame_start,
  output logic       vblank
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [2:0]  DIV_LAST = 3'(CLK_DIV - 1);
  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  if (H_TOTAL > 1024) begin : g_h_total_too_big
    $error("H_TOTAL exceeds 1024");
  end
  if (V_TOTAL > 1024) begin : g_v_total_too_big
    $error("V_TOTAL exceeds 1024");
  end
  if (CLK_DIV < 1 || CLK_DIV > 8) begin : g_bad_clk_div
    $error("CLK_DIV must be 1..8");
  end
  if (PIX_LATENCY < 0 || PIX_LATENCY > 4) begin : g_bad_latency
    $error("PIX_LATENCY must be 0..4");
  end

  logic [2:0] div_cnt;
  logic       tick;
  logic       h_wrap;
  logic       v_wrap;
  logic [9:0] h_next;
  logic [9:0] v_next;
  logic [9:0] v_sel;

  // With CLK_DIV=1 DIV_LAST is 0, so tick is permanently high.
  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= 3'd0;
    end else if (tick) begin
      div_cnt <= 3'd0;
    end else begin
      div_cnt <= div_cnt + 3'd1;
    end
  end

  assign h_wrap = (horizCounter == H_LAST);
  assign v_wrap = (vertCounter == V_LAST);
  assign h_next = h_wrap ? 10'd0 : horizCounter + 10'd1;
  assign v_next = h_wrap ? (v_wrap ? 10'd0 : vertCounter + 10'd1) : vertCounter;
  assign v_sel  = tick ? v_next : vertCounter;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      horizCounter <= 10'd0;
      vertCounter  <= 10'd0;
      frame_start  <= 1'b0;
      vblank       <= 1'b0;
    end else begin
      if (tick) begin
        horizCounter <= h_next;
        vertCounter  <= v_next;
      end
      frame_start <= tick & h_wrap & v_wrap;
      // Built from the next line value so vblank tracks vertCounter exactly.
      vblank      <= ({1'b0, v_sel} >= V_ACT);
    end
  end

  logic       hs_raw;
  logic       vs_raw;
  logic       de_raw;
  logic [2:0] raw;
  logic [2:0] dly;

  assign hs_raw = ({1'b0, horizCounter} >= HS_START) && ({1'b0, horizCounter} < HS_END);
  assign vs_raw = ({1'b0, vertCounter} >= VS_START) && ({1'b0, vertCounter} < VS_END);
  assign de_raw = ({1'b0, horizCounter} < H_ACT) && ({1'b0, vertCounter} < V_ACT);
  assign raw    = {hs_raw, vs_raw, de_raw};

  if (PIX_LATENCY == 0) begin : g_no_delay
    // Counters sit at (0,0) during reset, so mask the pass-through to keep outputs inactive.
    assign dly = reset ? 3'b000 : raw;
  end else begin : g_delay
    logic [2:0] pipe [PIX_LATENCY];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < PIX_LATENCY; i++) begin
          pipe[i] <= 3'b000;
        end
      end else begin
        pipe[0] <= raw;
        for (int i = 1; i < PIX_LATENCY; i++) begin
          pipe[i] <= pipe[i-1];
        end
      end
    end

    assign dly = pipe[PIX_LATENCY-1];
  end

  assign hsync     = SYNC_POL ? dly[2] : ~dly[2];
  assign vsync     = SYNC_POL ? dly[1] : ~dly[1];
  assign video_on  = dly[0];
  assign pixel_out = pixel_bw & video_on;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - randomized bench for vga_timing_gen against an arithmetic raster model
module tb_vga_timing_gen;

  typedef struct {
    int ha, hf, hs, hb;
    int va, vf, vs, vb;
    int div, lat, pol;
  } cfg_t;

  localparam cfg_t CA = '{640, 16, 96, 48, 480, 10, 2, 33, 1, 1, 0};
  localparam cfg_t CB = '{8, 2, 3, 2, 4, 1, 2, 1, 2, 3, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b, pb_a, pb_b;
  logic [9:0] h_a, v_a, h_b, v_b;
  logic       hs_a, vs_a, vo_a, po_a, fs_a, vb_a;
  logic       hs_b, vs_b, vo_b, po_b, fs_b, vb_b;

  int tests;
  int errors;
  int n_a;
  int n_b;

  vga_timing_gen dut_a (
    .clk(clk), .reset(rst_a), .pixel_bw(pb_a),
    .horizCounter(h_a), .vertCounter(v_a),
    .hsync(hs_a), .vsync(vs_a), .video_on(vo_a), .pixel_out(po_a),
    .frame_start(fs_a), .vblank(vb_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .CLK_DIV(2), .PIX_LATENCY(3), .SYNC_POL(1'b1)
  ) dut_b (
    .clk(clk), .reset(rst_b), .pixel_bw(pb_b),
    .horizCounter(h_b), .vertCounter(v_b),
    .hsync(hs_b), .vsync(vs_b), .video_on(vo_b), .pixel_out(po_b),
    .frame_start(fs_b), .vblank(vb_b)
  );

  // Clock edges seen since the last reset release.
  always @(posedge clk or posedge rst_a) if (rst_a) n_a <= 0; else n_a <= n_a + 1;
  always @(posedge clk or posedge rst_b) if (rst_b) n_b <= 0; else n_b <= n_b + 1;

  task automatic cmp(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic void raw_at(input cfg_t c, input int n, output logic hs, output logic vs, output logic de);
    int ht, vt, t, h, v;
    ht = c.ha + c.hf + c.hs + c.hb;
    vt = c.va + c.vf + c.vs + c.vb;
    t  = n / c.div;
    h  = t % ht;
    v  = (t / ht) % vt;
    hs = (h >= c.ha + c.hf) && (h < c.ha + c.hf + c.hs);
    vs = (v >= c.va + c.vf) && (v < c.va + c.vf + c.vs);
    de = (h < c.ha) && (v < c.va);
  endfunction

  // Expected outputs after n clock edges since release: ticks elapsed = n/div, raster
  // position follows by division, delayed flags come from the position lat edges earlier.
  function automatic void model(input cfg_t c, input int n, output int eh, output int ev,
                                output logic ehs, output logic evs, output logic evo,
                                output logic efs, output logic evb);
    int ht, vt, t, tp;
    logic hr, vr, dr;
    ht  = c.ha + c.hf + c.hs + c.hb;
    vt  = c.va + c.vf + c.vs + c.vb;
    t   = n / c.div;
    tp  = (n > 0) ? (n - 1) / c.div : 0;
    eh  = t % ht;
    ev  = (t / ht) % vt;
    evb = (ev >= c.va);
    efs = (n > 0) && (t != tp) && ((t % (ht * vt)) == 0);
    if (n >= c.lat) raw_at(c, n - c.lat, hr, vr, dr);
    else begin hr = 1'b0; vr = 1'b0; dr = 1'b0; end
    ehs = (c.pol != 0) ? hr : !hr;
    evs = (c.pol != 0) ? vr : !vr;
    evo = dr;
  endfunction

  task automatic check_dut(input string nm, input cfg_t c, input logic r, input int n,
                           input logic [9:0] h, input logic [9:0] v, input logic hs, input logic vs,
                           input logic vo, input logic po, input logic fs, input logic vb, input logic pb);
    int eh, ev;
    logic ehs, evs, evo, efs, evb;
    if (r) begin
      eh = 0; ev = 0; ehs = (c.pol == 0); evs = (c.pol == 0);
      evo = 1'b0; efs = 1'b0; evb = 1'b0;
    end else begin
      model(c, n, eh, ev, ehs, evs, evo, efs, evb);
    end
    cmp({nm, "_horiz"}, int'(h), eh);
    cmp({nm, "_vert"}, int'(v), ev);
    cmp({nm, "_hsync"}, int'(hs), int'(ehs));
    cmp({nm, "_vsync"}, int'(vs), int'(evs));
    cmp({nm, "_video_on"}, int'(vo), int'(evo));
    cmp({nm, "_pixel_out"}, int'(po), int'(pb & evo));
    cmp({nm, "_frame_start"}, int'(fs), int'(efs));
    cmp({nm, "_vblank"}, int'(vb), int'(evb));
  endtask

  always @(negedge clk) begin
    check_dut("a", CA, rst_a, n_a, h_a, v_a, hs_a, vs_a, vo_a, po_a, fs_a, vb_a, pb_a);
    check_dut("b", CB, rst_b, n_b, h_b, v_b, hs_b, vs_b, vo_b, po_b, fs_b, vb_b, pb_b);
  end

  initial begin
    #5000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int eh, ev, cnt, vsc, rise, v0;
    logic ehs, evs, evo, efs, evb;
    tests = 0; errors = 0;
    rst_a = 1'b1; rst_b = 1'b1; pb_a = 1'b1; pb_b = 1'b0;

    // Hand-derived points that pin the model.
    model(CA, 656, eh, ev, ehs, evs, evo, efs, evb); cmp("model_a_hs_656", int'(ehs), 1);
    model(CA, 657, eh, ev, ehs, evs, evo, efs, evb); cmp("model_a_hs_657", int'(ehs), 0);
    model(CA, 753, eh, ev, ehs, evs, evo, efs, evb); cmp("model_a_hs_753", int'(ehs), 1);
    model(CA, 800, eh, ev, ehs, evs, evo, efs, evb); cmp("model_a_line_wrap", eh * 1000 + ev, 1);
    model(CB, 240, eh, ev, ehs, evs, evo, efs, evb); cmp("model_b_fs_240", int'(efs), 1);
    model(CB, 242, eh, ev, ehs, evs, evo, efs, evb); cmp("model_b_vo_242", int'(evo), 0);
    model(CB, 243, eh, ev, ehs, evs, evo, efs, evb); cmp("model_b_vo_243", int'(evo), 1);
    model(CB, 153, eh, ev, ehs, evs, evo, efs, evb); cmp("model_b_vs_153", int'(evs), 1);

    repeat (5) @(posedge clk);
    @(negedge clk);
    cmp("rst_a_horiz", int'(h_a), 0);
    cmp("rst_a_hsync", int'(hs_a), 1);
    cmp("rst_a_vsync", int'(vs_a), 1);
    cmp("rst_a_video_on", int'(vo_a), 0);
    cmp("rst_a_pixel_out", int'(po_a), 0);
    @(posedge clk); #1 rst_a = 1'b0; rst_b = 1'b0;

    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); @(negedge clk);
      if (k == 1) cmp("a_first_edge_horiz", int'(h_a), 1);
      if (k == 5) cmp("a_fifth_edge_horiz", int'(h_a), 5);
    end

    cnt = 0;
    while (hs_a && cnt < 2000) begin @(negedge clk); cnt++; end
    cmp("a_hsync_fall_horiz", int'(h_a), 657);
    cnt = 0;
    while (!hs_a && cnt < 2000) begin cnt++; @(negedge clk); end
    cmp("a_hsync_low_clks", cnt, 96);
    cmp("a_hsync_rise_horiz", int'(h_a), 753);

    cnt = 0;
    for (int i = 0; i < 800; i++) begin @(negedge clk); if (po_a) cnt++; end
    cmp("a_pixel_on_per_line", cnt, 640);

    cnt = 0;
    while (h_a != 10'd799 && cnt < 2000) begin @(negedge clk); cnt++; end
    v0 = int'(v_a);
    @(negedge clk);
    cmp("a_line_wrap_horiz", int'(h_a), 0);
    cmp("a_line_wrap_vert", int'(v_a), v0 + 1);

    cnt = 0;
    while (!fs_b && cnt < 1000) begin @(negedge clk); cnt++; end
    cmp("b_frame_start_seen", int'(fs_b), 1);
    cmp("b_wrap_horiz", int'(h_b), 0);
    cmp("b_wrap_vert", int'(v_b), 0);
    cnt = 0; vsc = 0; rise = -1;
    do begin
      @(negedge clk); cnt++;
      if (vs_b) vsc++;
      if (vo_b && rise < 0) rise = cnt;
    end while (!fs_b && cnt < 1000);
    cmp("b_frame_period", cnt, 240);
    cmp("b_vsync_active_clks", vsc, 60);
    cmp("b_video_on_rise", rise, 3);

    cnt = 0;
    while (!(h_b == 10'd5 && v_b == 10'd3) && cnt < 600) begin @(negedge clk); cnt++; end
    cmp("b_reached_5_3", int'(h_b) * 1000 + int'(v_b), 5003);
    @(posedge clk); #1 rst_b = 1'b1;
    @(negedge clk);
    cmp("b_midrst_horiz", int'(h_b), 0);
    cmp("b_midrst_vert", int'(v_b), 0);
    cmp("b_midrst_hsync", int'(hs_b), 0);
    cmp("b_midrst_video_on", int'(vo_b), 0);
    @(posedge clk); @(posedge clk); #1 rst_b = 1'b0;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (fs_b || cnt >= 1000) break;
      cnt++;
    end
    cmp("b_first_fs_after_reset", cnt, 240);

    for (int it = 0; it < 30; it++) begin
      int len;
      len = $urandom_range(5, 300);
      for (int i = 0; i < len; i++) begin
        @(posedge clk); #1;
        pb_a = 1'($urandom);
        pb_b = 1'($urandom);
      end
      @(posedge clk); #1;
      if ($urandom_range(0, 1) == 0) rst_a = 1'b1; else rst_b = 1'b1;
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1 rst_a = 1'b0; rst_b = 1'b0;
    end
    repeat (300) @(posedge clk);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
